// File: rtl/mac_fp_pkg.sv
// Shared encodings for the FP MAC dot-product sequencer: operand modes,
// sequencer states and sticky-flag bit positions.
package mac_fp_pkg;

    localparam logic [1:0] MODE_FP16 = 2'b00;
    localparam logic [1:0] MODE_MIX  = 2'b01;
    localparam logic [1:0] MODE_FP32 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // The reserved encoding 11 behaves as fp32.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == 2'b11) ? MODE_FP32 : mode;
    endfunction

endpackage

// File: rtl/mac_fp_dot_seq.sv
// Dot-product sequencer wrapped around the FP MAC: issues one operand pair at a
// time, feeds each MAC result back as the accumulator and returns the final sum.
module mac_fp_dot_seq
    import mac_fp_pkg::*;
#(
    parameter int PARM_RM = 3,
    parameter int MAC_LAT = 2,
    parameter int K_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [K_W-1:0]     k_len_i,
    input  logic [1:0]         mode_i,
    input  logic [PARM_RM-1:0] rm_i,
    input  logic [31:0]        init_acc_i,
    input  logic               op_valid_i,
    output logic               op_ready_o,
    input  logic [31:0]        op_a_i,
    input  logic [31:0]        op_b_i,
    output logic [31:0]        mac_in1_o,
    output logic [31:0]        mac_in2_o,
    output logic [127:0]       mac_in3_o,
    output logic [1:0]         mac_mode_o,
    output logic [PARM_RM-1:0] mac_rm_o,
    input  logic [127:0]       mac_out_i,
    input  logic               mac_nv_i,
    input  logic               mac_of_i,
    input  logic               mac_uf_i,
    input  logic               mac_nx_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output logic [31:0]        res_data_o,
    output logic [3:0]         res_flags_o,
    output logic               busy_o
);

    localparam int CNT_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAC_LAT);

    state_t           state;
    logic [31:0]      acc_q;
    logic [K_W-1:0]   remaining;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       flags_q;
    logic [3:0]       mac_flags;

    // Only the low word of the MAC result is ever meaningful here.
    logic unused_mac_hi;
    assign unused_mac_hi = ^mac_out_i[127:32];

    always_comb begin
        mac_flags         = '0;
        mac_flags[FLG_NV] = mac_nv_i;
        mac_flags[FLG_OF] = mac_of_i;
        mac_flags[FLG_UF] = mac_uf_i;
        mac_flags[FLG_NX] = mac_nx_i;
    end

    assign mac_in3_o   = {96'b0, acc_q};
    assign res_data_o  = acc_q;
    assign res_flags_o = flags_q;

    // NOTE: every register, datapath included, is cleared by the synchronous
    // reset so an abandoned dot product leaves nothing behind on the MAC ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc_q       <= '0;
            remaining   <= '0;
            wait_cnt    <= '0;
            flags_q     <= '0;
            mac_in1_o   <= '0;
            mac_in2_o   <= '0;
            mac_mode_o  <= MODE_FP16;
            mac_rm_o    <= '0;
            op_ready_o  <= 1'b0;
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge value of state, counters and flags.
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mac_mode_o <= norm_mode(mode_i);
                        mac_rm_o   <= rm_i;
                        acc_q      <= init_acc_i;
                        remaining  <= k_len_i;
                        flags_q    <= '0;
                        busy_o     <= 1'b1;
                        if (k_len_i == '0) begin
                            state       <= DONE;
                            res_valid_o <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            op_ready_o <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    if (op_valid_i) begin
                        mac_in1_o  <= op_a_i;
                        mac_in2_o  <= op_b_i;
                        wait_cnt   <= '0;
                        op_ready_o <= 1'b0;
                        state      <= WAIT;
                    end
                end

                WAIT: begin
                    // Operands have been stable since acceptance; capture once
                    // the MAC latency has elapsed.
                    if (wait_cnt == CNT_LAST) begin
                        acc_q   <= mac_out_i[31:0];
                        flags_q <= flags_q | mac_flags;
                        if (remaining != '0) begin
                            remaining <= remaining - 1'b1;
                        end
                        if (remaining <= K_W'(1)) begin
                            state       <= DONE;
                            res_valid_o <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            op_ready_o <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (res_ready_i) begin
                        state       <= IDLE;
                        res_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                    end
                end

                default: begin
                    state       <= IDLE;
                    op_ready_o  <= 1'b0;
                    res_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
